shift_register_unit: RTL and testbench
======================================

# shift_register_unit

Multi-cycle shift register that executes the 3-bit shift commands produced by the funct-to-shift decoder in the multicycle MIPS datapath. It holds a 32-bit operand, loads it on command, and performs logical/arithmetic shifts and rotations one bit position per clock. It reports progress to the control unit with a `busy`/`done` handshake. It sits between the register file output (operand, shift amount) and the write-back mux.

## Interface

- `WIDTH`, 32, operand width in bits.
- `SHAMT_W`, 5, shift-amount width; must satisfy 2**SHAMT_W >= WIDTH.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command strobe, sampled on the rising edge.
- `cmd`  in  3  command code (encoding below).
- `shamt`  in  SHAMT_W  shift/rotate count, captured with the command.
- `data_in`  in  WIDTH  operand, used only by the load command.
- `data_out`  out  WIDTH  current register contents; always visible.
- `busy`  out  1  high while a command is in progress (states SHIFT and DONE).
- `done`  out  1  one-cycle pulse; the result on `data_out` is final.

## Operation

**Command encoding** (fixed, shared package):
- 000: nop
- 001: load
- 010: sll
- 011: srl
- 100: sra
- 101: ror
- 110: rol
- 111: reserved

**Acceptance:** a command is accepted on a rising edge where `cmd_valid`=1, `busy`=0 and `cmd` is not 000 or 111.
- Nop, reserved codes, and any `cmd_valid` while busy are ignored: no state change and no `done`.
- On accept, `cmd` and `shamt` are latched into `op_q` and `cnt_q`.
- Later changes on the inputs do not affect the running operation.

**States:** IDLE, SHIFT, DONE.
- IDLE → DONE on an accepted load. `data_reg` ← `data_in` on the same edge.
- IDLE → DONE on an accepted shift/rotate with `shamt`=0. `data_reg` is unchanged.
- IDLE → SHIFT on an accepted shift/rotate with `shamt`>0. `cnt_q` ← `shamt`.
- SHIFT, each edge:
  - `data_reg` ← one-bit step of `op_q`.
  - `cnt_q` ← `cnt_q`−1.
  - Go to DONE on the edge where `cnt_q`=1; otherwise stay in SHIFT.
- DONE → IDLE unconditionally after one cycle.

**One-bit step:**
- sll: {d[W-2:0],0}
- srl: {0,d[W-1:1]}
- sra: {d[W-1],d[W-1:1]}
- ror: {d[0],d[W-1:1]}
- rol: {d[W-2:0],d[W-1]}

**Boundary conditions:**
- Shift counts ≥ WIDTH are executed literally:
  - sll/srl with `shamt`=31 leave one surviving bit.
  - sra saturates to all-sign.
  - Rotations are modulo WIDTH in effect.
- Reset asserted mid-operation: immediate return to IDLE, `data_reg`=0 and `cnt_q`=0. The partial result is lost and no `done` is issued.

## Timing

**Reset values:** `data_out`=0, `busy`=0, `done`=0, state IDLE.

**Latency** (accept edge = E0):
- Load, or shift with `shamt`=0: `done`=1 and `busy`=1 during the cycle after E0. Back in IDLE one cycle later.
- Shift with `shamt`=n>0:
  - Steps are applied on edges E1…En.
  - `done`=1 during the cycle after En.
  - Total is n+1 cycles from accept to the `done` cycle.
  - `busy`=1 from after E0 through the `done` cycle.

**Intermediate values:** `data_out` shows the partial result after each step. Consumers must sample only when `done`=1 or later; `data_reg` holds its value in IDLE.

**Back-to-back:** the earliest next accept is the edge ending the `done` cycle is not allowed (`busy`=1). A new command is accepted on the first edge with `busy`=0, i.e. one cycle after `done`.

## Structure

- Package `shift_pkg`:
  - localparams for the seven command codes, CMD_NOP through CMD_ROL, plus CMD_RSVD.
  - state enum {S_IDLE, S_SHIFT, S_DONE}.
  - `WIDTH` / `SHAMT_W` defaults.
- Sub-module `shift_step`: purely combinational. Inputs are `op` and `d`; output is the one-bit-stepped `d`.
- Top level: state register, `cnt_q`, `op_q`, `data_reg`.

## Test plan

- **Reset:** assert `reset`=0 mid-SHIFT of an sll by 20 → `data_out`=0, `busy`=0, no `done`. After release, load 0x0000_00FF → `done` in the next cycle and `data_out`=0x0000_00FF.
- **Logical shifts:**
  - load 0x8000_0001, then sll by 4 → `done` 5 cycles after accept, `data_out`=0x0000_0010.
  - srl by 31 of 0x8000_0000 → `data_out`=0x0000_0001.
- **Arithmetic shift:** load 0xF000_0000, sra by 8 → `data_out`=0xFFF0_0000. Load 0x7000_0000, sra by 8 → 0x0070_0000.
- **Rotations:** load 0x1234_5678, ror by 4 → 0x8123_4567; then rol by 4 → 0x1234_5678. `busy` is high exactly 5 cycles each.
- **Zero and ignored commands:**
  - sll with `shamt`=0 → `done` in the next cycle, `data_out` unchanged.
  - cmd 000 or 111 with `cmd_valid`=1 → no `busy`, no `done`.
  - Load issued while busy → ignored; the running result is unaffected.
- **Input stability:** change `shamt` and `cmd` every cycle during SHIFT → the result matches the values latched at accept.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared command codes, FSM states and default widths for the multi-cycle shifter.
package shift_pkg;

   localparam int WIDTH_DEF   = 32;
   localparam int SHAMT_W_DEF = 5;

   localparam logic [2:0] CMD_NOP  = 3'b000;
   localparam logic [2:0] CMD_LOAD = 3'b001;
   localparam logic [2:0] CMD_SLL  = 3'b010;
   localparam logic [2:0] CMD_SRL  = 3'b011;
   localparam logic [2:0] CMD_SRA  = 3'b100;
   localparam logic [2:0] CMD_ROR  = 3'b101;
   localparam logic [2:0] CMD_ROL  = 3'b110;
   localparam logic [2:0] CMD_RSVD = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/shift_step.sv
// One-bit shift/rotate step, purely combinational.
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_comb begin
      q = d;
      case (op)
         CMD_SLL: q = {d[WIDTH-2:0], 1'b0};
         CMD_SRL: q = {1'b0, d[WIDTH-1:1]};
         CMD_SRA: q = {d[WIDTH-1], d[WIDTH-1:1]};
         CMD_ROR: q = {d[0], d[WIDTH-1:1]};
         CMD_ROL: q = {d[WIDTH-2:0], d[WIDTH-1]};
         default: q = d;
      endcase
   end

endmodule

// File: rtl/shift_register_unit.sv
// Multi-cycle shifter: loads an operand, then applies one shift/rotate bit per clock.
// Reports progress with busy (command in flight) and a one-cycle done pulse.
module shift_register_unit
   import shift_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int SHAMT_W = SHAMT_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cmd_valid,
   input  logic [2:0]         cmd,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [WIDTH-1:0]   data_in,
   output logic [WIDTH-1:0]   data_out,
   output logic               busy,
   output logic               done
);

   state_t             state, state_n;
   logic [SHAMT_W-1:0] cnt_q;
   logic [2:0]         op_q;
   logic [WIDTH-1:0]   data_reg;
   logic [WIDTH-1:0]   step_d;
   logic               accept;

   // Commands are only taken from IDLE; everything else on the strobe is dropped.
   assign accept = cmd_valid && (state == S_IDLE) &&
                   (cmd != CMD_NOP) && (cmd != CMD_RSVD);

   shift_step #(.WIDTH(WIDTH)) u_step (
      .op (op_q),
      .d  (data_reg),
      .q  (step_d)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if ((cmd == CMD_LOAD) || (shamt == '0)) begin
                  state_n = S_DONE;
               end else begin
                  state_n = S_SHIFT;
               end
            end
         end
         S_SHIFT: begin
            if (cnt_q == SHAMT_W'(1)) begin
               state_n = S_DONE;
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_reg <= '0;
         cnt_q    <= '0;
         op_q     <= CMD_NOP;
      end else if (accept) begin
         op_q  <= cmd;
         cnt_q <= shamt;
         if (cmd == CMD_LOAD) begin
            data_reg <= data_in;
         end
      end else if (state == S_SHIFT) begin
         data_reg <= step_d;
         cnt_q    <= cnt_q - SHAMT_W'(1);
      end
   end

   assign data_out = data_reg;
   assign busy     = (state != S_IDLE);
   assign done     = (state == S_DONE);

endmodule

// File: tb/tb_shift_register_unit.sv
// Bench for shift_register_unit: directed literal cases plus randomized traffic against a cycle-level model.
module tb_shift_register_unit;
   import shift_pkg::*;

   logic        clk;
   logic        reset;
   logic        cmd_valid;
   logic [2:0]  cmd;
   logic [4:0]  shamt;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        busy;
   logic        done;

   int checks   = 0;
   int failures = 0;

   shift_register_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd       (cmd),
      .shamt     (shamt),
      .data_in   (data_in),
      .data_out  (data_out),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Result of applying k single-bit steps of op to d, computed directly.
   function automatic logic [31:0] apply(input logic [2:0] op, input logic [31:0] d, input int k);
      logic [31:0] r;
      r = d;
      case (op)
         CMD_SLL: r = d << k;
         CMD_SRL: r = d >> k;
         CMD_SRA: r = $unsigned($signed(d) >>> k);
         CMD_ROR: r = (d >> k) | (d << (32 - k));
         CMD_ROL: r = (d << k) | (d >> (32 - k));
         default: r = d;
      endcase
      return r;
   endfunction

   // Model: m_rem = busy cycles still to come including the current one.
   logic [31:0] m_cur, m_base;
   logic [2:0]  m_op;
   int          m_n, m_steps, m_rem;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_cur <= '0; m_base <= '0; m_op <= CMD_NOP;
         m_n <= 0; m_steps <= 0; m_rem <= 0;
      end else if (m_rem > 0) begin
         m_rem <= m_rem - 1;
         if (m_steps < m_n) begin
            m_steps <= m_steps + 1;
            m_cur   <= apply(m_op, m_base, m_steps + 1);
         end
      end else if (cmd_valid && cmd != CMD_NOP && cmd != CMD_RSVD) begin
         m_op    <= cmd;
         m_steps <= 0;
         if (cmd == CMD_LOAD) begin
            m_cur <= data_in;
            m_n   <= 0;
            m_rem <= 1;
         end else begin
            m_base <= m_cur;
            m_n    <= int'(shamt);
            m_rem  <= int'(shamt) + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         chk("model_data", data_out, m_cur);
         chk("model_busy", {31'b0, busy}, {31'b0, m_rem > 0});
         chk("model_done", {31'b0, done}, {31'b0, m_rem == 1});
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle;
      int n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      chk("idle_reached", {31'b0, busy}, 32'd0);
   endtask

   task automatic issue(input logic [2:0] op, input logic [4:0] sh, input logic [31:0] din);
      wait_idle();
      cmd_valid = 1'b1; cmd = op; shamt = sh; data_in = din;
      tick();
      cmd_valid = 1'b0; cmd = CMD_NOP;
   endtask

   // Issues a command and returns cycles from accept edge to the done cycle and the final result.
   task automatic run(input logic [2:0] op, input logic [4:0] sh, input logic [31:0] din,
                      input bit noise, output int lat, output logic [31:0] res);
      issue(op, sh, din);
      lat = 1;
      while (!done && lat < 80) begin
         if (noise) begin
            cmd_valid = 1'b1;
            cmd       = 3'($urandom_range(0, 7));
            shamt     = 5'($urandom_range(0, 31));
            data_in   = $urandom;
         end
         tick();
         lat++;
      end
      chk("done_seen", {31'b0, done}, 32'd1);
      res = data_out;
      cmd_valid = 1'b0; cmd = CMD_NOP;
      tick();
   endtask

   int          lat;
   logic [31:0] res;

   initial begin
      reset = 1'b0; cmd_valid = 1'b0; cmd = CMD_NOP; shamt = '0; data_in = '0;
      repeat (2) tick();
      chk("reset_data", data_out, 32'h0);
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_done", {31'b0, done}, 32'd0);
      reset = 1'b1;
      tick();

      // Reset in the middle of an sll by 20
      run(CMD_LOAD, 5'd0, 32'hFFFF_FFFF, 1'b0, lat, res);
      issue(CMD_SLL, 5'd20, 32'h0);
      repeat (5) tick();
      reset = 1'b0;
      #1;
      chk("midrst_data", data_out, 32'h0);
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      chk("midrst_done", {31'b0, done}, 32'd0);
      repeat (2) begin
         tick();
         chk("midrst_hold_done", {31'b0, done}, 32'd0);
      end
      reset = 1'b1;
      tick();
      chk("postrst_busy", {31'b0, busy}, 32'd0);

      run(CMD_LOAD, 5'd0, 32'h0000_00FF, 1'b0, lat, res);
      chk("load_lat", 32'(lat), 32'd1);
      chk("load_data", res, 32'h0000_00FF);

      run(CMD_LOAD, 5'd0, 32'h8000_0001, 1'b0, lat, res);
      run(CMD_SLL, 5'd4, 32'h0, 1'b0, lat, res);
      chk("sll4_lat", 32'(lat), 32'd5);
      chk("sll4_data", res, 32'h0000_0010);

      run(CMD_LOAD, 5'd0, 32'h8000_0000, 1'b0, lat, res);
      run(CMD_SRL, 5'd31, 32'h0, 1'b0, lat, res);
      chk("srl31_data", res, 32'h0000_0001);
      chk("srl31_lat", 32'(lat), 32'd32);

      run(CMD_LOAD, 5'd0, 32'hF000_0000, 1'b0, lat, res);
      run(CMD_SRA, 5'd8, 32'h0, 1'b0, lat, res);
      chk("sra_neg", res, 32'hFFF0_0000);
      run(CMD_LOAD, 5'd0, 32'h7000_0000, 1'b0, lat, res);
      run(CMD_SRA, 5'd8, 32'h0, 1'b0, lat, res);
      chk("sra_pos", res, 32'h0070_0000);

      run(CMD_LOAD, 5'd0, 32'h1234_5678, 1'b0, lat, res);
      run(CMD_ROR, 5'd4, 32'h0, 1'b0, lat, res);
      chk("ror4_data", res, 32'h8123_4567);
      chk("ror4_busy_cycles", 32'(lat), 32'd5);
      run(CMD_ROL, 5'd4, 32'h0, 1'b0, lat, res);
      chk("rol4_data", res, 32'h1234_5678);
      chk("rol4_busy_cycles", 32'(lat), 32'd5);

      run(CMD_SLL, 5'd0, 32'h0, 1'b0, lat, res);
      chk("sll0_lat", 32'(lat), 32'd1);
      chk("sll0_data", res, 32'h1234_5678);

      // Nop and reserved codes must not start anything
      cmd_valid = 1'b1; cmd = CMD_NOP; data_in = 32'hAAAA_AAAA;
      tick();
      chk("nop_busy", {31'b0, busy}, 32'd0);
      cmd = CMD_RSVD;
      tick();
      chk("rsvd_busy", {31'b0, busy}, 32'd0);
      chk("rsvd_done", {31'b0, done}, 32'd0);
      chk("rsvd_data", data_out, 32'h1234_5678);
      cmd_valid = 1'b0; cmd = CMD_NOP;
      tick();

      // Commands and operand churn while busy are ignored
      run(CMD_LOAD, 5'd0, 32'h0000_00F0, 1'b0, lat, res);
      run(CMD_SRL, 5'd4, 32'h0, 1'b1, lat, res);
      chk("busy_ignore_data", res, 32'h0000_000F);
      chk("busy_ignore_lat", 32'(lat), 32'd5);
      run(CMD_LOAD, 5'd0, 32'hC0DE_0001, 1'b0, lat, res);
      run(CMD_ROL, 5'd12, 32'h0, 1'b1, lat, res);
      chk("stable_rol12", res, 32'hE000_1C0D);

      for (int i = 0; i < 600; i++) begin
         cmd_valid = ($urandom_range(0, 3) != 0);
         cmd       = 3'($urandom_range(0, 7));
         shamt     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
         data_in   = $urandom;
         if ($urandom_range(0, 99) == 0) begin
            #1 reset = 1'b0;
            #1 reset = 1'b1;
         end
         tick();
      end
      cmd_valid = 1'b0;
      repeat (40) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
